// File: rtl/ram_sp_lanes.sv
// ram_sp_lanes: parametrised single-port synchronous RAM with per-lane write
// enables, registered read port with valid strobe, selectable read-during-write
// behaviour and a clear engine that fills every word after reset or on request.
module ram_sp_lanes #(
   parameter int unsigned          DATA_W      = 8,
   parameter int unsigned          ADDR_W      = 3,
   parameter int unsigned          DEPTH       = 1 << ADDR_W,
   parameter int unsigned          LANES       = 1,
   parameter int unsigned          WRITE_FIRST = 0,
   parameter logic [DATA_W-1:0]    FILL        = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   output logic                 busy,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   input  logic [LANES-1:0]     we,
   input  logic                 re,
   output logic [DATA_W-1:0]    rdata,
   output logic                 rvalid
);

   localparam int unsigned          LANE_W  = DATA_W / LANES;
   localparam logic [0:0]           S_CLEAR = 1'b0;
   localparam logic [0:0]           S_IDLE  = 1'b1;
   localparam logic [ADDR_W-1:0]    LAST    = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]      DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [0:0]          r_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_busy;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rvalid;

   logic [0:0]          w_state_nxt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic                w_busy_nxt;
   logic                w_in_range;
   logic                w_access;
   logic                w_wr_en;
   logic                w_rd_en;
   logic [DATA_W-1:0]   w_old;
   logic [DATA_W-1:0]   w_merged;

   assign busy   = r_busy;
   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;

   // Decode of a user access accepted on this edge
   assign w_in_range = {1'b0, addr} < DEPTH_X;
   assign w_access   = (r_state == S_IDLE) && !clr;
   assign w_wr_en    = w_access && (|we) && w_in_range;
   assign w_rd_en    = w_access && re;

   // Old word and lane-merged new word; out-of-range addresses read as FILL
   always_comb begin
      w_old    = w_in_range ? r_mem[addr] : FILL;
      w_merged = w_old;
      for (int i = 0; i < int'(LANES); i++) begin
         if (we[i]) begin
            w_merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
         end
      end
      if (!w_in_range) begin
         w_merged = FILL;
      end
   end

   // Next-state logic: clear sweep ends on the last word, clr restarts it
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      case (r_state)
         S_CLEAR: begin
            if (r_cnt == LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end else begin
               w_cnt_nxt   = r_cnt + ADDR_W'(1);
            end
         end
         default: begin
            if (clr) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end
         end
      endcase
   end

   // State register; reset restarts the clear sweep from word 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Storage array: fill writes while clearing, merged user writes when idle
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= FILL;
         end else if (w_wr_en) begin
            r_mem[addr] <= w_merged;
         end
      end
   end

   // Registered read port; rdata holds when no read is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd_en;
         if (w_rd_en) begin
            r_rdata <= (WRITE_FIRST != 0) ? w_merged : w_old;
         end
      end
   end

endmodule

// File: tb/tb_ram_sp_lanes.sv
// Testbench for ram_sp_lanes: two instances (depth 8 read-first, depth 6
// write-first) share one stimulus stream; a behavioural model predicts each.
module tb_ram_sp_lanes;

   localparam logic [15:0] FILLV = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        re  = 1'b0;
   logic [2:0]  addr  = '0;
   logic [15:0] wdata = '0;
   logic [1:0]  we    = '0;

   logic        busy_a, busy_b, rvalid_a, rvalid_b;
   logic [15:0] rdata_a, rdata_b;

   always #5 clk = ~clk;

   ram_sp_lanes #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .LANES(2),
                  .WRITE_FIRST(0), .FILL(FILLV)) u_a (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy_a), .addr(addr),
      .wdata(wdata), .we(we), .re(re), .rdata(rdata_a), .rvalid(rvalid_a));

   ram_sp_lanes #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .LANES(2),
                  .WRITE_FIRST(1), .FILL(FILLV)) u_b (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy_b), .addr(addr),
      .wdata(wdata), .we(we), .re(re), .rdata(rdata_b), .rvalid(rvalid_b));

   // Reference model state, one slot per instance
   int          depth_m [2] = '{8, 6};
   int          wf_m    [2] = '{0, 1};
   logic [15:0] mem_m   [2][8];
   int          rem_m   [2];
   logic        exp_busy[2];
   logic        exp_rv  [2];
   logic [15:0] exp_rd  [2];
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock edge of behaviour for instance k, from the inputs sampled there
   task automatic model_step(input int k);
      logic [15:0] old_w, new_w;
      if (rst) begin
         rem_m[k]    = depth_m[k];
         exp_busy[k] = 1'b1;
         exp_rd[k]   = '0;
         exp_rv[k]   = 1'b0;
      end else if (rem_m[k] > 0) begin
         rem_m[k]--;
         exp_rv[k] = 1'b0;
         if (rem_m[k] == 0) begin
            for (int j = 0; j < 8; j++) mem_m[k][j] = FILLV;
            exp_busy[k] = 1'b0;
         end
      end else if (clr) begin
         rem_m[k]    = depth_m[k];
         exp_busy[k] = 1'b1;
         exp_rv[k]   = 1'b0;
      end else begin
         if (int'(addr) < depth_m[k]) begin
            old_w = mem_m[k][addr];
            new_w = old_w;
            if (we[0]) new_w[7:0]  = wdata[7:0];
            if (we[1]) new_w[15:8] = wdata[15:8];
            mem_m[k][addr] = new_w;
         end else begin
            old_w = FILLV;
            new_w = FILLV;
         end
         exp_rv[k] = re;
         if (re) begin
            exp_rd[k] = (wf_m[k] != 0) ? new_w : old_w;
            if (k == 0) q_a.push_back(exp_rd[k]);
            else        q_b.push_back(exp_rd[k]);
         end
      end
   endtask

   task automatic cyc(input logic r, input logic c, input logic [2:0] a,
                      input logic [15:0] d, input logic [1:0] w, input logic e);
      rst = r; clr = c; addr = a; wdata = d; we = w; re = e;
      @(posedge clk);
      model_step(0);
      model_step(1);
      if (r) chk_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] w);
      cyc(1'b0, 1'b0, a, d, w, 1'b0);
   endtask

   task automatic rd(input logic [2:0] a);
      cyc(1'b0, 1'b0, a, 16'h0, 2'b00, 1'b1);
   endtask

   // Monitor: per-cycle status checks plus scoreboard pop on each rvalid
   always @(negedge clk) begin
      logic [15:0] e;
      if (chk_en) begin
         chk("busy_a",   16'(busy_a),   16'(exp_busy[0]));
         chk("busy_b",   16'(busy_b),   16'(exp_busy[1]));
         chk("rvalid_a", 16'(rvalid_a), 16'(exp_rv[0]));
         chk("rvalid_b", 16'(rvalid_b), 16'(exp_rv[1]));
         chk("rhold_a",  rdata_a,       exp_rd[0]);
         chk("rhold_b",  rdata_b,       exp_rd[1]);
         if (rvalid_a === 1'b1) begin
            if (q_a.size() == 0) chk("sb_a_unexpected", 16'h1, 16'h0);
            else begin e = q_a.pop_front(); chk("sb_a", rdata_a, e); end
         end
         if (rvalid_b === 1'b1) begin
            if (q_b.size() == 0) chk("sb_b_unexpected", 16'h1, 16'h0);
            else begin e = q_b.pop_front(); chk("sb_b", rdata_b, e); end
         end
      end
   end

   initial begin
      // Reset, then the post-reset clear sweep
      cyc(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
      idle(10);
      for (int i = 0; i < 8; i++) rd(3'(i));

      // Lane writes and merge
      wr(3'd3, 16'h1234, 2'b11);
      wr(3'd3, 16'hFF00, 2'b10);
      rd(3'd3);

      // Read during write at the same address
      wr(3'd5, 16'h0001, 2'b11);
      cyc(1'b0, 1'b0, 3'd5, 16'h0002, 2'b11, 1'b1);
      rd(3'd5);

      // Out-of-range write and read (instance b has depth 6)
      wr(3'd7, 16'hBEEF, 2'b11);
      rd(3'd7);
      for (int i = 0; i < 6; i++) rd(3'(i));
      cyc(1'b0, 1'b0, 3'd7, 16'h5A5A, 2'b01, 1'b1);

      // clr mid-traffic: write in the clr cycle is ignored, reads while busy
      for (int i = 0; i < 8; i++) wr(3'(i), 16'(i * 4369 + 7), 2'b11);
      cyc(1'b0, 1'b1, 3'd2, 16'hDEAD, 2'b11, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 3'(i), 16'h1111, 2'b11, 1'b1);
      idle(5);
      for (int i = 0; i < 8; i++) rd(3'(i));

      // Reset in the middle of a clear sweep
      for (int i = 0; i < 8; i++) wr(3'(i), 16'(i * 771 + 3), 2'b11);
      cyc(1'b0, 1'b1, 3'd0, 16'h0, 2'b00, 1'b0);
      idle(4);
      cyc(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
      idle(9);
      for (int i = 0; i < 8; i++) rd(3'(i));

      // Randomised traffic with occasional clr and rst
      for (int n = 0; n < 600; n++) begin
         cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 39) == 0),
             3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      end
      idle(12);
      for (int i = 0; i < 8; i++) rd(3'(i));
      idle(2);

      chk("sb_a_drained", 16'(q_a.size()), 16'h0);
      chk("sb_b_drained", 16'(q_b.size()), 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_sp_lanes.md
# ram_sp_lanes

Parametrised single-port synchronous RAM that generalises the 8x8 memory to arbitrary width and depth. It adds per-lane write enables, a registered read port with a valid strobe, a selectable read-during-write mode, and a built-in clear engine that fills every word after reset or on request. It is a drop-in storage element for register files, lookup tables and scratch buffers in the memories library.

## Interface

Parameters:
- DATA_W, 8, word width in bits; must be divisible by LANES.
- ADDR_W, 3, address width.
- DEPTH, 1<<ADDR_W, number of words; 1 <= DEPTH <= 2^ADDR_W.
- LANES, 1, write-enable lanes; lane width is DATA_W/LANES.
- WRITE_FIRST, 0, read-during-write mode: 0 is read-first (old data), 1 is write-first (new data).
- FILL, 0, DATA_W-bit value written by the clear engine.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  single-cycle request to refill the whole memory with FILL.
- busy  out  1  clear engine active; user accesses ignored.
- addr  in  ADDR_W  word address for read and write.
- wdata  in  DATA_W  write data.
- we  in  LANES  per-lane write enable; bit i covers wdata[i*DATA_W/LANES +: DATA_W/LANES].
- re  in  1  read enable.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata was updated by a read accepted on the previous edge.

## Operation

- FSM states: CLEAR and IDLE.
- Reset: while rst=1, state=CLEAR, clear counter cnt=0, busy=1, rdata=0, rvalid=0.
- CLEAR state:
  - Each edge with rst=0 writes FILL to mem[cnt] and increments cnt.
  - On the edge that writes cnt==DEPTH-1, go to IDLE, busy=0, cnt=0.
  - we, re and clr are ignored. rvalid=0. rdata holds its value.
- IDLE state, clr=1:
  - Go to CLEAR with cnt=0 and busy=1 on the next edge.
  - Any we or re in that same cycle is ignored.
- IDLE state, clr=0:
  - For each lane i with we[i]=1 and addr<DEPTH, write that lane of wdata into mem[addr]. Lanes with we[i]=0 are unchanged.
  - If re=1, update rdata on the edge:
    - WRITE_FIRST=0: rdata = mem[addr] before this edge's write.
    - WRITE_FIRST=1: rdata = the merged word, i.e. written lanes from wdata and the other lanes from the old value.
  - rvalid <= re, else 0.
  - If re=0, rdata holds.
- Out-of-range addresses (addr>=DEPTH):
  - Writes are dropped.
  - Reads return FILL with rvalid=1.
- rst has priority over everything. Asserting rst mid-clear restarts the clear at cnt=0.
- No access-ordering hazards exist beyond the same-cycle read/write described above. A write is visible to any read issued on a later cycle.

## Timing

- Read latency: 1 cycle. re/addr sampled at edge N; rdata and rvalid are valid after edge N, for the cycle N to N+1.
- Write latency: 0. Data is in the array after the sampling edge.
- Clear duration: exactly DEPTH cycles with busy=1. This counts from the first cycle rst=0 after reset, or from the edge that accepts clr.
- busy falls on the same edge that performs the last fill write. The first user access is accepted on the following edge.
- Throughput: one read and/or one write per cycle in IDLE. There are no stalls.
- All outputs are driven directly from registers; there are no combinational paths from inputs to outputs.

## Test plan

- Reset clear (DATA_W=16, ADDR_W=3, FILL=16'hA5A5):
  - Release rst; busy stays 1 for exactly 8 cycles, then 0.
  - Reading addr 0..7 returns 16'hA5A5 with rvalid one cycle after each re.
- Lane writes (LANES=2):
  - Write 16'h1234, we=2'b11, to addr 3.
  - Then write 16'hFF00, we=2'b10, to addr 3.
  - Read addr 3 gives 16'hFF34.
- Read-during-write:
  - mem[5]=16'h0001; same cycle we=2'b11, wdata=16'h0002, re=1, addr=5.
  - Expect rdata=16'h0001 with WRITE_FIRST=0, and 16'h0002 with WRITE_FIRST=1.
  - A follow-up read gives 16'h0002 in both modes.
- clr mid-traffic:
  - Fill all words with distinct values; pulse clr together with we=2'b11 to addr 2.
  - The write is ignored and busy is 1 for 8 cycles.
  - re during busy gives rvalid=0. Afterwards every word equals FILL.
- Reset mid-clear:
  - Assert rst at cnt=4, hold 2 cycles, release.
  - busy lasts a full 8 more cycles and all words equal FILL.
- Non-power-of-2 depth (ADDR_W=3, DEPTH=6):
  - Clear takes 6 cycles.
  - Write 16'hBEEF to addr 7 is dropped.
  - Read addr 7 returns FILL with rvalid=1, and addr 0..5 are unaffected.
